// File: rtl/pc_gen.sv
// Instruction fetch address generator: boot sequencing, branch/flush redirect, stalled-branch capture.
// Optional build macro DELAY_SLOT_EN: branch redirects mark a delay slot instead of killing IF.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic [31:0] pc,
  output logic        rom_en,
  output logic        kill_if,
  output logic        in_delay_slot,
  output logic        fetch_addr_err
);

  typedef enum logic [1:0] {StBoot, StRun, StPend} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        rom_en_q, kill_q, ds_q, err_q;
  logic        rom_en_d, kill_d, ds_d, err_d;
  logic        flush_taken, br_taken;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    flush_taken = 1'b0;
    br_taken    = 1'b0;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        pc_d    = RESET_PC;
      end
      StRun: begin
        if (flush) begin
          flush_taken = 1'b1;
          pc_d        = flush_pc;
          pend_d      = '0;
        end else if (branch_flag && !stall) begin
          br_taken = 1'b1;
          pc_d     = branch_addr;
        end else if (branch_flag) begin
          // Target captured now; ID may move on while IF is held.
          pend_d  = branch_addr;
          state_d = StPend;
        end else if (!stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      StPend: begin
        if (flush) begin
          flush_taken = 1'b1;
          pc_d        = flush_pc;
          pend_d      = '0;
          state_d     = StRun;
        end else if (!stall) begin
          br_taken = 1'b1;
          pc_d     = pend_q;
          pend_d   = '0;
          state_d  = StRun;
        end
      end
      default: begin
        state_d = StBoot;
        pc_d    = RESET_PC;
        pend_d  = '0;
      end
    endcase

    rom_en_d = (state_d != StBoot);
    err_d    = (pc_d[1:0] != 2'b00);
`ifdef DELAY_SLOT_EN
    kill_d = flush_taken;
    ds_d   = br_taken;
`else
    kill_d = flush_taken | br_taken;
    ds_d   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      pend_q   <= '0;
      rom_en_q <= 1'b0;
      kill_q   <= 1'b0;
      ds_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      rom_en_q <= rom_en_d;
      kill_q   <= kill_d;
      ds_q     <= ds_d;
      err_q    <= err_d;
    end
  end

  assign pc             = pc_q;
  assign rom_en         = rom_en_q;
  assign kill_if        = kill_q;
  assign in_delay_slot  = ds_q;
  assign fetch_addr_err = err_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural fetch-address model.
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] pc;
  logic        rom_en, kill_if, in_delay_slot, fetch_addr_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_flag   (branch_flag),
    .branch_addr   (branch_addr),
    .pc            (pc),
    .rom_en        (rom_en),
    .kill_if       (kill_if),
    .in_delay_slot (in_delay_slot),
    .fetch_addr_err(fetch_addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch unit must present after each edge.
  bit          m_valid = 1'b0;
  bit          m_boot;
  bit          m_pend;
  logic [31:0] m_target;
  logic [31:0] m_pc;
  bit          m_rom, m_kill, m_ds, m_err;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_boot  = 1'b1;
      m_pend  = 1'b0;
      m_pc    = RST_PC;
      m_rom   = 1'b0;
      m_kill  = 1'b0;
      m_ds    = 1'b0;
      m_err   = 1'b0;
    end else if (m_valid) begin
      m_kill = 1'b0;
      m_ds   = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
        m_pc   = RST_PC;
      end else if (flush) begin
        m_pc   = flush_pc;
        m_pend = 1'b0;
        m_kill = 1'b1;
      end else if (m_pend) begin
        if (!stall) begin
          m_pc   = m_target;
          m_pend = 1'b0;
          if (DS) m_ds = 1'b1; else m_kill = 1'b1;
        end
      end else if (branch_flag && !stall) begin
        m_pc = branch_addr;
        if (DS) m_ds = 1'b1; else m_kill = 1'b1;
      end else if (branch_flag) begin
        m_pend   = 1'b1;
        m_target = branch_addr;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
      m_rom = 1'b1;
      m_err = (m_pc % 4) != 0;
    end
    #1;
    if (m_valid) begin
      chk("model_pc", pc, m_pc);
      chk("model_rom_en", {31'd0, rom_en}, {31'd0, m_rom});
      chk("model_kill_if", {31'd0, kill_if}, {31'd0, m_kill});
      chk("model_in_delay_slot", {31'd0, in_delay_slot}, {31'd0, m_ds});
      chk("model_fetch_addr_err", {31'd0, fetch_addr_err}, {31'd0, m_err});
    end
  end

  // Inputs change 2 time units after the edge, outputs are stable by then.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    stall = 0; flush = 0; branch_flag = 0;
  endtask

  task automatic do_flush(input logic [31:0] a);
    flush = 1; flush_pc = a;
    tick();
    flush = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    if ($urandom_range(0, 15) == 0) a = 32'hFFFFFFF0;
    return a;
  endfunction

  initial begin
    // Power-on reset, two cycles.
    tick();
    tick();
    rst = 0;
    chk("boot_pc", pc, 32'hBFC00000);
    chk("boot_rom_en", {31'd0, rom_en}, 32'd0);
    tick();
    chk("first_fetch_pc", pc, 32'hBFC00000);
    chk("first_fetch_rom_en", {31'd0, rom_en}, 32'd1);
    tick();
    chk("seq_pc_4", pc, 32'hBFC00004);
    tick();
    chk("seq_pc_8", pc, 32'hBFC00008);

    // Direct branch, no stall.
    do_flush(32'h00400010);
    chk("flush_kill", {31'd0, kill_if}, 32'd1);
    chk("flush_pc", pc, 32'h00400010);
    branch_flag = 1; branch_addr = 32'h00400100;
    tick();
    branch_flag = 0;
    chk("br_pc", pc, 32'h00400100);
    chk("br_kill", {31'd0, kill_if}, DS ? 32'd0 : 32'd1);
    chk("br_ds", {31'd0, in_delay_slot}, DS ? 32'd1 : 32'd0);
    tick();
    chk("br_after_pc", pc, 32'h00400104);
    chk("br_after_kill", {31'd0, kill_if}, 32'd0);

    // Stalled branch: first target kept, second ignored.
    branch_flag = 1; branch_addr = 32'h00001000; stall = 1;
    tick();
    branch_flag = 0;
    chk("pend_hold1", pc, 32'h00400104);
    tick();
    chk("pend_hold2", pc, 32'h00400104);
    tick();
    chk("pend_hold3", pc, 32'h00400104);
    branch_flag = 1; branch_addr = 32'h00002000;
    tick();
    branch_flag = 0; stall = 0;
    chk("pend_hold4", pc, 32'h00400104);
    tick();
    chk("pend_release_pc", pc, 32'h00001000);
    chk("pend_release_kill", {31'd0, kill_if}, DS ? 32'd0 : 32'd1);
    tick();
    chk("pend_after_pc", pc, 32'h00001004);

    // Flush wins over a stalled branch in the same cycle.
    flush = 1; flush_pc = 32'hBFC00380; branch_flag = 1; branch_addr = 32'h00003000; stall = 1;
    tick();
    idle();
    chk("flush_win_pc", pc, 32'hBFC00380);
    chk("flush_win_kill", {31'd0, kill_if}, 32'd1);
    tick();
    chk("flush_nopend_pc1", pc, 32'hBFC00384);
    chk("flush_nopend_kill", {31'd0, kill_if}, 32'd0);
    tick();
    chk("flush_nopend_pc2", pc, 32'hBFC00388);

    // Wrap and misaligned target.
    do_flush(32'hFFFFFFFC);
    tick();
    chk("wrap_pc", pc, 32'h00000000);
    chk("wrap_err", {31'd0, fetch_addr_err}, 32'd0);
    branch_flag = 1; branch_addr = 32'h00400102;
    tick();
    branch_flag = 0;
    chk("misalign_pc", pc, 32'h00400102);
    chk("misalign_err", {31'd0, fetch_addr_err}, 32'd1);
    do_flush(32'h00000100);
    chk("realign_err", {31'd0, fetch_addr_err}, 32'd0);

    // Reset while a target is pending.
    branch_flag = 1; branch_addr = 32'h00005000; stall = 1;
    tick();
    idle();
    stall = 1;
    rst = 1;
    tick();
    chk("rst_pend_pc", pc, 32'hBFC00000);
    chk("rst_pend_rom", {31'd0, rom_en}, 32'd0);
    chk("rst_pend_kill", {31'd0, kill_if}, 32'd0);
    chk("rst_pend_ds", {31'd0, in_delay_slot}, 32'd0);
    chk("rst_pend_err", {31'd0, fetch_addr_err}, 32'd0);
    rst = 0; stall = 0;
    tick();
    chk("rst_restart_pc0", pc, 32'hBFC00000);
    chk("rst_restart_rom", {31'd0, rom_en}, 32'd1);
    tick();
    chk("rst_restart_pc4", pc, 32'hBFC00004);

    // Randomized traffic, checked every cycle by the model process.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      stall       = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 11) == 0);
      flush_pc    = rand_addr();
      branch_flag = ($urandom_range(0, 3) == 0);
      branch_addr = rand_addr();
      tick();
    end
    rst = 0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
